bldc_commutator: RTL and testbench

Six-step (trapezoidal) commutation controller for one BLDC motor. Filters the three hall inputs, selects per-phase drive from the rotor position and commanded direction, and slew-limits the commanded duty cycle. Produces `duty_cycle`/`high_z` pairs for three downstream phase driver instances (phases A, B, C). Latches a fault on illegal hall codes.

---
 rtl/bldc_commutator_pkg.sv | 43 ++++
 rtl/bldc_commutator_hall_filter.sv | 47 ++++
 rtl/bldc_commutator.sv | 145 ++++++++++++++
 tb/tb_bldc_commutator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_commutator_pkg.sv
// Shared types and the six-step commutation table for the BLDC commutator.
package bldc_commutator_pkg;

    localparam int DUTY_CYCLE_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_C    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    typedef struct packed {
        logic [1:0] pwm;
        logic [1:0] low;
    } phase_sel_t;

    function automatic logic hall_legal(input logic [2:0] h);
        return (h != 3'b000) && (h != 3'b111);
    endfunction

    // Hall code is {C,B,A}; reverse rotation swaps the driven and grounded phase.
    function automatic phase_sel_t commutate(input logic [2:0] h, input logic fwd);
        phase_sel_t s;
        case (h)
            3'b101:  s = '{pwm: PH_A, low: PH_B};
            3'b100:  s = '{pwm: PH_A, low: PH_C};
            3'b110:  s = '{pwm: PH_B, low: PH_C};
            3'b010:  s = '{pwm: PH_B, low: PH_A};
            3'b011:  s = '{pwm: PH_C, low: PH_A};
            3'b001:  s = '{pwm: PH_C, low: PH_B};
            default: s = '{pwm: PH_NONE, low: PH_NONE};
        endcase
        if (!fwd) s = '{pwm: s.low, low: s.pwm};
        return s;
    endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input synchronizer and stability filter; accepts a code after HALL_STABLE equal samples.
module hall_filter #(
    parameter int HALL_STABLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] hall,
    output logic [2:0] hall_filt,
    output logic       hall_change
);

    logic [2:0] sync_p0;
    logic [2:0] sync_p1;
    logic [2:0] cand_p2;
    logic [7:0] cnt_p2;
    logic [7:0] cnt_nx;

    // Count includes the current sample, so HALL_STABLE=1 accepts on the first new sample.
    always_comb begin
        cnt_nx = 8'd1;
        if (sync_p1 == cand_p2) begin
            cnt_nx = (cnt_p2 == 8'(HALL_STABLE)) ? cnt_p2 : cnt_p2 + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0     <= 3'b000;
            sync_p1     <= 3'b000;
            cand_p2     <= 3'b000;
            cnt_p2      <= 8'd0;
            hall_filt   <= 3'b000;
            hall_change <= 1'b0;
        end else begin
            sync_p0     <= hall;
            sync_p1     <= sync_p0;
            cand_p2     <= sync_p1;
            cnt_p2      <= cnt_nx;
            hall_change <= 1'b0;
            if (cnt_nx == 8'(HALL_STABLE) && sync_p1 != hall_filt) begin
                hall_filt   <= sync_p1;
                hall_change <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: hall filtering, state control, duty slew and phase selection.
module bldc_commutator
    import bldc_commutator_pkg::*;
#(
    parameter int DUTY_CYCLE_WIDTH = DUTY_CYCLE_WIDTH_DEFAULT,
    parameter int HALL_STABLE      = 16,
    parameter int SLEW_DIV         = 64,
    parameter int SLEW_STEP        = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        direction,
    input  logic                        brake,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cmd,
    input  logic [2:0]                  hall,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic                        hall_fault,
    output logic [15:0]                 step_count
);

    localparam int W          = DUTY_CYCLE_WIDTH;
    localparam int SLEW_CNT_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam logic [SLEW_CNT_W-1:0] SLEW_LAST = SLEW_CNT_W'(SLEW_DIV - 1);
    localparam logic [W:0]            STEP_EXT  = (W + 1)'(SLEW_STEP);

    logic [2:0]            hall_filt;
    logic                  hall_change;
    state_t                state, state_nx;
    logic                  dir_p0;
    logic [W-1:0]          duty_applied, duty_nx;
    logic [SLEW_CNT_W-1:0] slew_cnt, slew_cnt_nx;
    phase_sel_t            sel;
    logic [W-1:0]          duty_o [3];
    logic [2:0]            hz_o;

    // One extra bit keeps the step from wrapping near full scale or below zero.
    function automatic logic [W-1:0] slew_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W:0] c, t, moved;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) begin
            moved = c + STEP_EXT;
            return (moved > t) ? tgt : moved[W-1:0];
        end else if (t < c) begin
            moved = (c > STEP_EXT) ? c - STEP_EXT : '0;
            return (moved < t) ? tgt : moved[W-1:0];
        end
        return cur;
    endfunction

    hall_filter #(.HALL_STABLE(HALL_STABLE)) u_hall_filter (
        .clock       (clock),
        .reset       (reset),
        .hall        (hall),
        .hall_filt   (hall_filt),
        .hall_change (hall_change)
    );

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (brake)                     state_nx = ST_BRAKE;
                          else if (hall_legal(hall_filt)) state_nx = ST_RUN;
                ST_RUN:   if (!hall_legal(hall_filt))    state_nx = ST_FAULT;
                          else if (brake)                state_nx = ST_BRAKE;
                ST_BRAKE: if (!hall_legal(hall_filt))    state_nx = ST_FAULT;
                          else if (!brake)               state_nx = ST_RUN;
                default:                                 state_nx = ST_FAULT;
            endcase
        end
    end

    // Ramp restarts from zero on RUN entry and on every direction reversal.
    always_comb begin
        duty_nx     = duty_applied;
        slew_cnt_nx = slew_cnt + SLEW_CNT_W'(1);
        if (state_nx != ST_RUN || state != ST_RUN || direction != dir_p0) begin
            duty_nx     = '0;
            slew_cnt_nx = '0;
        end else if (slew_cnt == SLEW_LAST) begin
            slew_cnt_nx = '0;
            duty_nx     = slew_toward(duty_applied, duty_cmd);
        end
    end

    always_comb begin
        sel = commutate(hall_filt, direction);
        for (int p = 0; p < 3; p++) begin
            duty_o[p] = '0;
            hz_o[p]   = 1'b1;
            if (state_nx == ST_BRAKE) begin
                hz_o[p] = 1'b0;
            end else if (state_nx == ST_RUN) begin
                if (sel.pwm == 2'(p)) begin
                    duty_o[p] = duty_nx;
                    hz_o[p]   = 1'b0;
                end else if (sel.low == 2'(p)) begin
                    hz_o[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            dir_p0       <= 1'b0;
            duty_applied <= '0;
            slew_cnt     <= '0;
            hall_fault   <= 1'b0;
            step_count   <= 16'd0;
            duty_a       <= '0;
            duty_b       <= '0;
            duty_c       <= '0;
            high_z_a     <= 1'b1;
            high_z_b     <= 1'b1;
            high_z_c     <= 1'b1;
        end else begin
            state        <= state_nx;
            dir_p0       <= direction;
            duty_applied <= duty_nx;
            slew_cnt     <= slew_cnt_nx;
            hall_fault   <= (state_nx == ST_FAULT);
            if (state == ST_RUN && hall_change && hall_legal(hall_filt)) begin
                step_count <= step_count + 16'd1;
            end
            duty_a   <= duty_o[0];
            duty_b   <= duty_o[1];
            duty_c   <= duty_o[2];
            high_z_a <= hz_o[0];
            high_z_b <= hz_o[1];
            high_z_c <= hz_o[2];
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: table-driven rotation with a scoreboard queue plus hand-written corner sequences.
module tb_bldc_commutator;

    localparam int DW = 10;
    localparam int HS = 16;

    logic          clock = 1'b0;
    logic          reset, enable, direction, brake;
    logic [DW-1:0] duty_cmd;
    logic [2:0]    hall;
    logic [DW-1:0] duty_a, duty_b, duty_c;
    logic          high_z_a, high_z_b, high_z_c, hall_fault;
    logic [15:0]   step_count;

    bldc_commutator #(
        .DUTY_CYCLE_WIDTH (DW),
        .HALL_STABLE      (HS),
        .SLEW_DIV         (64),
        .SLEW_STEP        (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .brake      (brake),
        .duty_cmd   (duty_cmd),
        .hall       (hall),
        .duty_a     (duty_a),
        .duty_b     (duty_b),
        .duty_c     (duty_c),
        .high_z_a   (high_z_a),
        .high_z_b   (high_z_b),
        .high_z_c   (high_z_c),
        .hall_fault (hall_fault),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int run_start;
    int exp_steps;

    typedef struct {
        logic [2:0] code;
        int         pwm;
        int         low;
    } vec_t;

    typedef struct {
        logic [2:0]  code;
        logic [2:0]  hz;
        int          pwm;
        logic [15:0] steps;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] hz_of(input int pwm, input int low);
        logic [2:0] h = 3'b111;
        h[pwm] = 1'b0;
        h[low] = 1'b0;
        return h;
    endfunction

    // Upward ramp from zero: +4 every 64 clocks, clamped at the target.
    function automatic int exp_ramp(input int edges, input int tgt);
        int v = 4 * (edges / 64);
        return (v > tgt) ? tgt : v;
    endfunction

    task automatic check_phases(input string name, input logic [2:0] exp_hz, input int pwm, input int exp_duty);
        logic [3*DW-1:0] exp_d = '0;
        if (pwm >= 0 && pwm < 3) exp_d[pwm*DW +: DW] = DW'(exp_duty);
        check({name, " high_z"}, {29'd0, high_z_c, high_z_b, high_z_a}, {29'd0, exp_hz});
        check({name, " duty"}, {2'b00, duty_c, duty_b, duty_a}, {2'b00, exp_d});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tbl[0] = '{3'b101, 0, 1};
        tbl[1] = '{3'b100, 0, 2};
        tbl[2] = '{3'b110, 1, 2};
        tbl[3] = '{3'b010, 1, 0};
        tbl[4] = '{3'b011, 2, 0};
        tbl[5] = '{3'b001, 2, 1};

        reset = 1'b1; enable = 1'b0; direction = 1'b1; brake = 1'b0;
        duty_cmd = '0; hall = 3'b101;
        tick(3);
        check("reset hall_fault", 32'(hall_fault), 32'd0);
        check("reset step_count", 32'(step_count), 32'd0);
        check_phases("reset", 3'b111, -1, 0);

        reset = 1'b0;
        tick(HS + 6);
        check_phases("idle float", 3'b111, -1, 0);

        // Forward rotation
        enable = 1'b1; duty_cmd = 10'd200;
        run_start = cyc + 1;
        tick(1);
        check_phases("run entry 101", hz_of(0, 1), 0, 0);
        exp_steps = 0;
        for (int i = 1; i < 6; i++) begin
            hall = tbl[i].code;
            exp_steps++;
            sb.push_back('{tbl[i].code, hz_of(tbl[i].pwm, tbl[i].low), tbl[i].pwm, 16'(exp_steps)});
            tick(HS + 2);
            check("step latency", 32'(step_count), 32'(exp_steps - 1));
            tick(1);
            e = sb.pop_front();
            check_phases($sformatf("fwd %b", e.code), e.hz, e.pwm, exp_ramp(cyc - run_start, 200));
            check($sformatf("fwd %b step_count", e.code), 32'(step_count), 32'(e.steps));
        end
        check("step total", 32'(step_count), 32'd5);

        // Slew reaches 200 exactly 50*64 clocks after RUN entry, with no overshoot
        while (cyc < run_start + 3199) tick(1);
        check_phases("slew 196", hz_of(2, 1), 2, 196);
        tick(1);
        check_phases("slew 200", hz_of(2, 1), 2, 200);
        tick(64);
        check_phases("slew hold", hz_of(2, 1), 2, 200);

        direction = 1'b0;
        tick(1);
        run_start = cyc;
        check_phases("dir flip", hz_of(1, 2), 1, 0);
        tick(64);
        check_phases("rev ramp", hz_of(1, 2), 1, 4);

        // Glitch one sample short of acceptance
        hall = 3'b011;
        tick(HS - 1);
        hall = 3'b001;
        tick(HS + 6);
        check_phases("glitch", hz_of(1, 2), 1, exp_ramp(cyc - run_start, 200));
        check("glitch step_count", 32'(step_count), 32'd5);

        // Illegal hall latches a fault
        hall = 3'b111;
        tick(HS + 2);
        check("fault early", 32'(hall_fault), 32'd0);
        tick(1);
        check("fault set", 32'(hall_fault), 32'd1);
        check_phases("fault float", 3'b111, -1, 0);
        hall = 3'b001;
        tick(HS + 6);
        check("fault held", 32'(hall_fault), 32'd1);
        check_phases("fault held", 3'b111, -1, 0);
        check("fault step_count", 32'(step_count), 32'd5);
        enable = 1'b0;
        tick(1);
        check("fault clear", 32'(hall_fault), 32'd0);
        check_phases("cleared idle", 3'b111, -1, 0);

        // Brake, taken together with a direction change
        enable = 1'b1;
        tick(1);
        run_start = cyc;
        check_phases("rerun", hz_of(1, 2), 1, 0);
        tick(70);
        check_phases("rerun ramp", hz_of(1, 2), 1, 4);
        brake = 1'b1; direction = 1'b1;
        tick(1);
        check_phases("brake", 3'b000, -1, 0);
        tick(5);
        check_phases("brake hold", 3'b000, -1, 0);
        brake = 1'b0;
        tick(1);
        run_start = cyc;
        check_phases("brake release", hz_of(2, 1), 2, 0);
        tick(64);
        check_phases("post brake ramp", hz_of(2, 1), 2, 4);

        // Enable drop in the same cycle the illegal code is accepted
        hall = 3'b000;
        tick(HS + 2);
        enable = 1'b0;
        tick(1);
        check("disable beats fault", 32'(hall_fault), 32'd0);
        check_phases("disable idle", 3'b111, -1, 0);

        // Reset from RUN
        enable = 1'b1; hall = 3'b001;
        tick(HS + 6);
        check_phases("pre reset run", hz_of(2, 1), 2, exp_ramp(cyc - (cyc - 2), 200));
        reset = 1'b1;
        tick(1);
        check("midrun reset step_count", 32'(step_count), 32'd0);
        check("midrun reset hall_fault", 32'(hall_fault), 32'd0);
        check_phases("midrun reset", 3'b111, -1, 0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
